// File: rtl/crc32_arb2_if.sv
// Bus bundle between the two frame sources, the shared CRC32 word engine and the
// result consumer of crc32_arb2.
interface crc32_arb2_if;
    logic [1:0]  s_valid;
    logic [1:0]  s_last;
    logic [31:0] s_data0;
    logic [31:0] s_data1;
    logic [1:0]  s_ready;
    logic        eng_init;
    logic        eng_valid;
    logic [31:0] eng_data;
    logic [31:0] eng_crc;
    logic        res_valid;
    logic        res_ready;
    logic        res_ch;
    logic [31:0] res_crc;
    logic        res_ok;
    logic [15:0] res_len;
    logic        res_err;

    modport slave (
        input  s_valid, s_last, s_data0, s_data1, eng_crc, res_ready,
        output s_ready, eng_init, eng_valid, eng_data,
        output res_valid, res_ch, res_crc, res_ok, res_len, res_err
    );

    modport master (
        output s_valid, s_last, s_data0, s_data1, eng_crc, res_ready,
        input  s_ready, eng_init, eng_valid, eng_data,
        input  res_valid, res_ch, res_crc, res_ok, res_len, res_err
    );
endinterface

// File: rtl/crc32_arb2.sv
// Two-channel round-robin frame sequencer for a shared CRC32 word engine.
// Define CRC32_ARB_TIMEOUT_EN to build the idle-beat watchdog (limit TIMEOUT cycles).
module crc32_arb2 #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    crc32_arb2_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_e;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        res_ch_q, res_ch_d;
    logic        res_ok_q, res_ok_d;
    logic        res_err_q, res_err_d;
    logic [31:0] res_crc_q, res_crc_d;
    logic [15:0] res_len_q, res_len_d;

    logic [1:0]  s_ready;
    logic        eng_init;
    logic        eng_valid;
    logic [31:0] eng_data;
    logic        res_valid;
    logic        sel_valid;
    logic        sel_last;
    logic [31:0] sel_data;
    logic        beat;
    logic        timeout_hit;

    assign sel_valid = grant_q ? bus.s_valid[1] : bus.s_valid[0];
    assign sel_last  = grant_q ? bus.s_last[1]  : bus.s_last[0];
    assign sel_data  = grant_q ? bus.s_data1    : bus.s_data0;
    assign beat      = (state_q == ST_STREAM) && sel_valid;

`ifdef CRC32_ARB_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Counts consecutive beat-less STREAM cycles; any beat or other state restarts it.
    always_comb begin
        idle_d = '0;
        if (state_q == ST_STREAM && !beat) begin
            idle_d = idle_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_STREAM) && !beat &&
                         (idle_q == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        res_ch_d  = res_ch_q;
        res_ok_d  = res_ok_q;
        res_err_d = res_err_q;
        res_crc_d = res_crc_q;
        res_len_d = res_len_q;
        s_ready   = 2'b00;
        eng_init  = 1'b0;
        eng_valid = 1'b0;
        eng_data  = '0;
        res_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.s_valid != 2'b00) begin
                    // On a tie the channel not served last wins.
                    grant_d = (bus.s_valid == 2'b11) ? ~last_q : bus.s_valid[1];
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                eng_init = 1'b1;
                cnt_d    = '0;
                err_d    = 1'b0;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                s_ready[grant_q] = 1'b1;
                if (beat) begin
                    eng_valid = 1'b1;
                    eng_data  = sel_data;
                    cnt_d     = cnt_q + 16'd1;
                    if (sel_last) begin
                        state_d = ST_WAIT;
                    end else if (cnt_d == MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The engine absorbed the final word on the previous edge.
                res_ch_d  = grant_q;
                res_crc_d = bus.eng_crc;
                res_ok_d  = (bus.eng_crc == 32'd0);
                res_len_d = cnt_q;
                res_err_d = err_q;
                state_d   = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    last_d  = res_ch_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            res_ch_q  <= 1'b0;
            res_ok_q  <= 1'b0;
            res_err_q <= 1'b0;
            res_crc_q <= '0;
            res_len_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            res_ch_q  <= res_ch_d;
            res_ok_q  <= res_ok_d;
            res_err_q <= res_err_d;
            res_crc_q <= res_crc_d;
            res_len_q <= res_len_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.eng_init  = eng_init;
    assign bus.eng_valid = eng_valid;
    assign bus.eng_data  = eng_data;
    assign bus.res_valid = res_valid;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_crc   = res_crc_q;
    assign bus.res_ok    = res_ok_q;
    assign bus.res_len   = res_len_q;
    assign bus.res_err   = res_err_q;
endmodule

// File: doc/crc32_arb2.md
# crc32_arb2

Two-channel frame arbiter and sequencer for the shared CRC32 word engine (32-bit data per cycle, all-ones seed, no final XOR). It grants one requester at a time, round-robin per frame, and seeds the engine. It streams the granted channel's words into the engine, then reports the frame result: raw CRC, zero-residue pass/fail, word count and error flag.

## Interface
- MAX_WORDS, default 256: maximum words per frame; 1..65535.
- TIMEOUT, default 64: idle-beat watchdog limit in cycles; used only with CRC32_ARB_TIMEOUT_EN.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  2  per-channel word valid; bit n is channel n.
- s_last  in  2  per-channel last word of frame.
- s_data0, s_data1  in  32 each  channel words.
- s_ready  out  2  per-channel accept; at most one bit is set.
- eng_init  out  1  one-cycle pulse; the engine loads 0xFFFFFFFF on the following edge.
- eng_valid  out  1  word strobe to the engine; the engine updates on the following edge.
- eng_data  out  32  word to the engine; 0 when eng_valid=0.
- eng_crc  in  32  current engine CRC register.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  result accept.
- res_ch  out  1  channel the result belongs to.
- res_crc  out  32  eng_crc captured at end of frame.
- res_ok  out  1  res_crc==0, i.e. a frame with an appended CRC passed.
- res_len  out  16  words accepted in the frame.
- res_err  out  1  frame aborted: length overflow or timeout.

## Operation
- **State IDLE**
  - If no s_valid bit is set, stay in IDLE.
  - Otherwise grant one channel and go to INIT.
  - Only one requesting: grant it. Both requesting: grant the channel not served last.
  - The last-served pointer resets to 1, so channel 0 wins the first tie.
- **State INIT**
  - eng_init=1 for exactly one cycle.
  - Clear the word counter, then go to STREAM.
- **State STREAM**
  - s_ready[grant]=1; s_ready of the other channel stays 0.
  - A beat is s_valid[grant] & s_ready[grant]. On a beat, eng_valid=1 and eng_data=s_data(grant) in the same cycle (combinational), and the counter increments.
  - A beat with s_last[grant]=1 goes to WAIT.
  - A beat that makes the count equal MAX_WORDS with s_last=0 sets the err flag and goes to WAIT. After that, s_ready=0 and further words of that frame are not consumed by this block.
- **State WAIT**
  - One cycle, so eng_crc reflects the final word.
  - Capture res_crc, res_ok, res_len, res_ch and res_err, then go to RESULT.
- **State RESULT**
  - res_valid=1 with stable result fields.
  - On res_ready=1: update the last-served pointer to res_ch, clear res_valid, and go to IDLE.
- s_valid on the non-granted channel is ignored until the current frame completes. It must remain pending, with no data loss.
- Counter width is 16; MAX_WORDS bounds it, so it never wraps.

## Timing
- Reset values:
  - State IDLE, pointer 1.
  - s_ready=0, eng_init=0, eng_valid=0, eng_data=0.
  - res_valid=0, res_ch=0, res_crc=0, res_ok=0, res_len=0, res_err=0.
- Grant latency, with s_valid first seen high at cycle 0 in IDLE:
  - cycle 1: INIT, eng_init=1.
  - cycle 2: STREAM, s_ready high.
- Result latency, with the last beat at cycle N: WAIT at N+1, res_valid=1 from N+2.
- Minimum frame turnaround, with res_ready tied high:
  - 1-word frame: 5 cycles (IDLE, INIT, STREAM, WAIT, RESULT).
  - Back-to-back frames add no extra cycle beyond this.
- eng_init and eng_valid are never high in the same cycle.
- res_valid high with res_ready low: hold all result fields; no new grant is made.
- Reset mid-frame: return to IDLE within one edge with all outputs at reset values. The partial frame is discarded and no result is produced.

## Configuration
- CRC32_ARB_TIMEOUT_EN defined:
  - In STREAM, a counter counts consecutive cycles with no beat; it resets on every beat.
  - When it reaches TIMEOUT: res_err=1, go to WAIT, then RESULT with res_len = words accepted so far.
- CRC32_ARB_TIMEOUT_EN undefined:
  - No watchdog logic is built; STREAM waits indefinitely for the next beat.
  - res_err is raised only by MAX_WORDS overflow.

## Test plan
- **Single channel 0, 3-word frame** 0x11111111, 0x22222222, 0x33333333 (last on the third), res_ready=1.
  - eng_init at cycle 1; three eng_valid pulses carrying exactly those words.
  - res_valid at cycle N+2; res_ch=0, res_len=3, res_err=0, res_crc equal to the model.
- **Residue check**: channel 1 sends 4 data words plus their model CRC as the 5th word.
  - res_len=5, res_crc=0, res_ok=1.
  - Flipping one bit in word 2 gives res_ok=0.
- **Round-robin**: both channels hold s_valid high continuously with 2-word frames.
  - Grant order 0, 1, 0, 1.
  - s_ready is never high on both bits; the non-granted channel's data is never forwarded.
- **Backpressure**: res_ready low for 10 cycles.
  - res_valid and all result fields are held; no eng_init and no s_ready during that time.
- **Overflow**: MAX_WORDS=4, a 6-word frame.
  - res_len=4, res_err=1; s_ready=0 after the 4th beat.
- **Reset and timeout**:
  - rst_n low for 1 cycle after 2 beats: all outputs return to reset values, and the next frame starts with eng_init.
  - With CRC32_ARB_TIMEOUT_EN and TIMEOUT=8, s_valid dropping after 1 beat gives res_err=1, res_len=1.
